// File: rtl/rr_grant_pkg.sv
// Shared types and sizing helpers for the round-robin grant controller
// and its rotating priority encoder.
package rr_grant_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RELEASE
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

    // Longest wait of a continuously requesting line with en held high.
    function automatic int max_wait(input int n, input int max_hold);
        return (n - 1) * (max_hold + 2) + 2;
    endfunction

endpackage

// File: rtl/rr_grant_props.sv
// Concurrent properties for rr_grant_ctrl, attached to every instance by bind:
// grant implies request, one-hot grants, bounded hold, expiry and fairness.
module rr_grant_props
    import rr_grant_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input logic         clk,
    input logic         rst_n,
    input logic         en,
    input logic [N-1:0] req,
    input logic [N-1:0] gnt,
    input logic         ok,
    input logic         expired
);

    localparam int unsigned WAIT_BOUND = max_wait(N, MAX_HOLD);

    int unsigned run_q;
    int unsigned wait_q [N];

    // Waiting only counts while new grants are permitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 0;
            for (int i = 0; i < N; i++) wait_q[i] <= 0;
        end else begin
            run_q <= (gnt != '0) ? run_q + 1 : 0;
            for (int i = 0; i < N; i++) begin
                if (req[i] && !gnt[i] && en) wait_q[i] <= wait_q[i] + 1;
                else                         wait_q[i] <= 0;
            end
        end
    end

    a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt & ~req) == '0);

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));

    a_ok: assert property (@(posedge clk) disable iff (!rst_n)
        ok == (|gnt));

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        run_q <= MAX_HOLD);

    a_expired: assert property (@(posedge clk) disable iff (!rst_n)
        expired |-> $past(gnt != '0));

    for (genvar g = 0; g < N; g++) begin : g_fair
        a_fair: assert property (@(posedge clk) disable iff (!rst_n)
            wait_q[g] <= WAIT_BOUND);
    end

endmodule

bind rr_grant_ctrl rr_grant_props #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
) u_props (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .ok      (ok),
    .expired (expired)
);

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request at or after ptr,
// wrapping modulo N.
module rr_pick
    import rr_grant_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   ptr,
    output logic [idx_width(N)-1:0]   idx,
    output logic                      valid
);

    localparam int IDX_W = idx_width(N);

    int pos;

    // NOTE: every output of a combinational block gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!valid && req[pos]) begin
                idx   = IDX_W'(pos);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin req/gnt controller: one owner at a time, grant held while the
// owner requests, forced release after MAX_HOLD cycles, then a 2-cycle gap.
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N-1:0]             req,
    output logic [N-1:0]             gnt,
    output logic                     ok,
    output logic [idx_width(N)-1:0]  owner,
    output logic                     expired
);

    localparam int IDX_W = idx_width(N);
    localparam int CNT_W = cnt_width(MAX_HOLD);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               exp_q, exp_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [N-1:0]       owner_oh;

    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        exp_d      = exp_q;
        case (state_q)
            ST_IDLE: begin
                if (en && pick_valid) begin
                    owner_d    = pick_idx;
                    hold_cnt_d = CNT_W'(1);
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // en is deliberately ignored here: it gates new grants only.
                if (!req[owner_q]) begin
                    exp_d   = 1'b0;
                    state_d = ST_RELEASE;
                end else if (hold_cnt_q == CNT_W'(MAX_HOLD)) begin
                    exp_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                ptr_d      = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
                hold_cnt_d = '0;
                exp_d      = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            exp_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            exp_q      <= exp_d;
        end
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // gnt follows req combinationally so a dropped request releases at once.
    assign gnt     = (state_q == ST_BUSY) ? (owner_oh & req) : '0;
    assign ok      = |gnt;
    assign owner   = owner_q;
    assign expired = (state_q == ST_RELEASE) && exp_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl (N=4, MAX_HOLD=8): directed scenarios
// plus random traffic, all compared against a grant-schedule model.
module tb_rr_grant_ctrl;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         ok;
    logic [1:0]   owner;
    logic         expired;

    int checks = 0;
    int errors = 0;

    rr_grant_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .ok      (ok),
        .owner   (owner),
        .expired (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Grant-schedule model: who holds the resource, for how long, and
    // whether this cycle is the post-grant cool-down.
    int m_owner;
    int m_last;
    int m_prio;
    int m_len;
    bit m_rel;
    bit m_exp;

    // Observations gathered per scenario.
    int           starts[$];
    int           exp_count;
    int           run_len;
    int           max_run;
    logic [N-1:0] prev_gnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last    = 0;
        m_prio    = 0;
        m_len     = 0;
        m_rel     = 1'b0;
        m_exp     = 1'b0;
        prev_gnt  = '0;
        run_len   = 0;
        max_run   = 0;
        exp_count = 0;
        starts.delete();
    endtask

    function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r);
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0 && r[m_owner]) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic e);
        if (m_owner >= 0) begin
            if (!r[m_owner] || m_len == MAX_HOLD) begin
                m_exp   = r[m_owner];
                m_rel   = 1'b1;
                m_prio  = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_len++;
            end
        end else if (m_rel) begin
            m_rel = 1'b0;
            m_exp = 1'b0;
        end else if (e && r != '0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_prio + k) % N]) begin
                    m_owner = (m_prio + k) % N;
                    m_last  = m_owner;
                    m_len   = 1;
                end
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic e);
        logic [N-1:0] g;
        @(negedge clk);
        req = r;
        en  = e;
        #1;
        g = model_gnt(r);
        check("gnt",     32'(gnt),     32'(g));
        check("ok",      32'(ok),      32'(g != '0));
        check("expired", 32'(expired), 32'(m_rel && m_exp));
        check("owner",   32'(owner),   32'(m_last));
        if (gnt != '0 && prev_gnt == '0)
            for (int i = 0; i < N; i++) if (gnt[i]) starts.push_back(i);
        if (expired) exp_count++;
        run_len  = (gnt != '0) ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        prev_gnt = gnt;
        @(posedge clk);
        model_step(r, e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},     32'(gnt),     32'(0));
        check({tag, "_ok"},      32'(ok),      32'(0));
        check({tag, "_expired"}, 32'(expired), 32'(0));
        check({tag, "_owner"},   32'(owner),   32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        en    = 1'b0;
        #1;
        check_reset_outputs("rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int start_at(input int i);
        return (i < starts.size()) ? starts[i] : -1;
    endfunction

    initial begin
        logic [N-1:0] r;
        logic         e;
        int           order [5] = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req   = '0;
        en    = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: grant to line 2 one cycle after arbitration.
        repeat (4) cycle(4'b0100, 1'b1);
        cycle(4'b0000, 1'b1);
        check("single_start", 32'(start_at(0)), 32'(2));

        // All lines requesting: full-length grants in rotating order.
        do_reset();
        repeat (51) cycle(4'b1111, 1'b1);
        check("rr_count", 32'(starts.size()), 32'(5));
        for (int i = 0; i < 5; i++) check("rr_order", 32'(start_at(i)), 32'(order[i]));
        check("rr_expired", 32'(exp_count), 32'(5));
        check("rr_maxrun",  32'(max_run),   32'(MAX_HOLD));

        // Voluntary release after 3 cycles: no expiry, next priority is 2.
        do_reset();
        repeat (4) cycle(4'b0010, 1'b1);
        repeat (2) cycle(4'b0000, 1'b1);
        repeat (2) cycle(4'b1111, 1'b1);
        check("vol_first",   32'(start_at(0)), 32'(1));
        check("vol_next",    32'(start_at(1)), 32'(2));
        check("vol_expired", 32'(exp_count),   32'(0));
        check("vol_len",     32'(max_run),     32'(3));

        // en low blocks new grants but never revokes an active one.
        do_reset();
        repeat (20) cycle(4'b0001, 1'b0);
        check("en_blocked", 32'(starts.size()), 32'(0));
        cycle(4'b0001, 1'b1);
        repeat (14) cycle(4'b0001, 1'b0);
        check("en_grants",  32'(starts.size()), 32'(1));
        check("en_expired", 32'(exp_count),     32'(1));
        check("en_maxrun",  32'(max_run),       32'(MAX_HOLD));

        // Wrap: owner 3 releases, next grant goes to 0.
        do_reset();
        cycle(4'b1000, 1'b1);
        repeat (12) cycle(4'b1001, 1'b1);
        check("wrap_first", 32'(start_at(0)), 32'(3));
        check("wrap_next",  32'(start_at(1)), 32'(0));

        // Random traffic with sticky requests and occasional en drops.
        do_reset();
        r = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
            e = ($urandom_range(0, 7) != 0);
            cycle(r, e);
        end

        // Asynchronous reset mid-grant, then arbitration restarts from line 0.
        do_reset();
        repeat (3) cycle(4'b0010, 1'b1);
        repeat (2) cycle(4'b0000, 1'b1);
        repeat (3) cycle(4'b0100, 1'b1);
        @(negedge clk);
        #2;
        check("pre_rst_gnt", 32'(gnt), 32'(model_gnt(4'b0100)));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        repeat (3) cycle(4'b1111, 1'b1);
        check("post_rst_first", 32'(start_at(0)), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin grant controller that shares one resource among N requesters on a req/gnt handshake. It holds each grant while the owner keeps requesting, up to a bounded number of cycles. It gates new grants with `en` and reports grant activity on `ok`. It sits between requester blocks and the shared resource, and it is the design under test for the lab's formal property set (grant implies request, one-hot grants, bounded hold, fairness).

## Interface
- `N`, default 4: number of requesters; must be ≥2.
- `MAX_HOLD`, default 8: maximum consecutive cycles a single grant may stay asserted; must be ≥1.
- `clk`, input, 1: single clock; all state updates on posedge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `en`, input, 1: permits new grants; does not revoke an active grant.
- `req`, input, N: per-requester request, level-sensitive.
- `gnt`, output, N: per-requester grant, one-hot or zero.
- `ok`, output, 1: high whenever any `gnt` bit is high.
- `owner`, output, $clog2(N): index of the current or last owner.
- `expired`, output, 1: one-cycle pulse marking a forced release caused by hold expiry.

## Operation
- Three-state FSM: IDLE, BUSY, RELEASE.
- Registered state: `state`, `ptr` (next-priority index), `owner`, `hold_cnt` (width $clog2(MAX_HOLD+1)), `exp_q`.
- IDLE:
  - If `en && |req`, pick the first set `req` bit scanning `ptr, ptr+1, …, N-1, 0, …` (mod N).
  - Load `owner` with the winner and set `hold_cnt` to 1, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `gnt = onehot(owner) & req`, combinational in `req`, so a grant without a request never occurs.
  - If `!req[owner]`, go to RELEASE with `exp_q` = 0 (voluntary release).
  - Else if `hold_cnt == MAX_HOLD`, go to RELEASE with `exp_q` = 1 (forced release).
  - Else increment `hold_cnt`.
  - Deasserting `en` in BUSY has no effect.
- RELEASE:
  - `gnt` = 0.
  - Load `ptr` with `(owner+1) mod N`, including on wrap from N-1 to 0.
  - Clear `hold_cnt` and go to IDLE.
- `expired` = `exp_q` while in RELEASE, else 0.
- `ok = |gnt`.
- A forced-release owner that still requests has the lowest priority in the next arbitration.
- Simultaneous requests: exactly one winner, chosen by `ptr` order.

## Timing
- Reset values (asynchronous on `rst_n` low): state IDLE, `ptr` = 0, `owner` = 0, `hold_cnt` = 0, `exp_q` = 0.
- Outputs during and immediately after reset: `gnt` = 0, `ok` = 0, `expired` = 0.
- Reset mid-grant: `gnt` drops asynchronously with `rst_n`, not at the next edge.
- Grant latency: `req` and `en` sampled high at edge E in IDLE → `gnt` high in the cycle after E.
- Release: `req[owner]` low → `gnt` low in the same cycle (combinational). FSM enters RELEASE at the next edge.
- Maximum grant length: `gnt[owner]` is high for at most MAX_HOLD consecutive cycles.
- Minimum gap between grants: 2 cycles with `gnt` = 0 (RELEASE, then IDLE).
- Worst-case wait for a continuously requesting line: (N-1)·(MAX_HOLD+2) + 2 cycles.
- `en` low for a single cycle in IDLE blocks arbitration in that cycle only.

## Structure
- Shared package `rr_grant_pkg`:
  - `state_t` enum {ST_IDLE, ST_BUSY, ST_RELEASE}.
  - Localparam helpers for index width and counter width.
- Sub-module `rr_pick`: purely combinational rotating priority encoder.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `idx`, `valid`.
  - Reused by future arbiters.
- Concurrent assertions in a separate bind module `rr_grant_props`:
  - `gnt[i] |-> req[i]`.
  - `$onehot0(gnt)`.
  - `ok == |gnt`.
  - Bounded hold.
  - `expired |-> $past(gnt != 0)`.
  - Fairness liveness.

## Test plan
All scenarios use N=4, MAX_HOLD=8.
- After reset, `en` = 1, `req` = 4'b0100 at edge 1 → `gnt` = 4'b0100 from cycle 2, `ok` = 1, `owner` = 2.
- `req` = 4'b1111 held with `en` = 1:
  - Grants in order 0, 1, 2, 3, 0.
  - Each grant lasts 8 cycles, followed by 2 idle cycles.
  - `expired` pulses once per grant.
- Owner 1 drops `req` after 3 grant cycles → `gnt` = 0 in the same cycle, `expired` stays 0, `ptr` = 2.
- `en` = 0 with `req` = 4'b0001 → `gnt` stays 0 indefinitely. Dropping `en` during an active grant keeps that grant until release.
- Wrap: owner 3 releases with `req` = 4'b1001 → next grant goes to 0.
- `rst_n` pulsed low mid-grant → `gnt`, `ok` and `expired` are 0 immediately. After reset, the first grant follows `ptr` = 0 order.
